// File: rtl/decode_issue_stage.sv
// ============================================================================
// Module      : decode_issue_stage
// Description : Decode/issue stage with writeback forwarding, busy-bit
//               scoreboard and a single-entry ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_issue_stage #(
    parameter int DATA_W  = 4,
    parameter int REG_AW  = 4,
    parameter int INSTR_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    output logic [REG_AW-1:0]  read_reg_num1,
    output logic [REG_AW-1:0]  read_reg_num2,
    input  logic [DATA_W-1:0]  read_data1,
    input  logic [DATA_W-1:0]  read_data2,
    input  logic               wb_regwrite,
    input  logic [REG_AW-1:0]  wb_reg,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_op,
    output logic [REG_AW-1:0]  out_rd,
    output logic [DATA_W-1:0]  out_a,
    output logic [DATA_W-1:0]  out_b,
    output logic               out_regwrite,
    output logic               illegal,
    output logic               halted
);

    localparam int NREGS = 1 << REG_AW;

    localparam logic [3:0] c_OP_NOP   = 4'h0;
    localparam logic [3:0] c_OP_ADD   = 4'h1;
    localparam logic [3:0] c_OP_XOR   = 4'h5;
    localparam logic [3:0] c_OP_ADDI  = 4'h6;
    localparam logic [3:0] c_OP_LOAD  = 4'h7;
    localparam logic [3:0] c_OP_STORE = 4'h8;
    localparam logic [3:0] c_OP_HALT  = 4'hF;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [NREGS-1:0]  busy_q, busy_d;
    logic              out_valid_q, out_valid_d;
    logic [3:0]        out_op_q, out_op_d;
    logic [REG_AW-1:0] out_rd_q, out_rd_d;
    logic [DATA_W-1:0] out_a_q, out_a_d;
    logic [DATA_W-1:0] out_b_q, out_b_d;
    logic              out_regwrite_q, out_regwrite_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        w_op;
    logic [REG_AW-1:0] w_rd, w_rs1, w_rs2;
    logic              w_uses_rs1, w_uses_rs2, w_regwrite;
    logic              w_is_illegal, w_is_bubble, w_is_halt;
    logic              w_hazard, w_slot_free, w_issue;
    logic [DATA_W-1:0] w_opnd1, w_opnd2;

    assign w_op  = in_instr[15:12];
    assign w_rd  = in_instr[11:8];
    assign w_rs1 = in_instr[7:4];
    assign w_rs2 = in_instr[3:0];

    assign read_reg_num1 = w_rs1;
    assign read_reg_num2 = w_rs2;

    assign w_uses_rs1   = (w_op >= c_OP_ADD) && (w_op <= c_OP_STORE);
    assign w_uses_rs2   = ((w_op >= c_OP_ADD) && (w_op <= c_OP_XOR)) || (w_op == c_OP_STORE);
    assign w_regwrite   = (w_op >= c_OP_ADD) && (w_op <= c_OP_LOAD) && (w_rd != '0);
    assign w_is_halt    = (w_op == c_OP_HALT);
    assign w_is_illegal = (w_op > c_OP_STORE) && !w_is_halt;
    assign w_is_bubble  = (w_op == c_OP_NOP) || w_is_illegal;

    // A busy bit cleared by this cycle's writeback no longer blocks issue.
    function automatic logic still_busy(input logic [REG_AW-1:0] r);
        return busy_q[r] && !(wb_regwrite && (wb_reg == r));
    endfunction

    // r0 reads as zero; otherwise forward the writeback that lands next edge.
    function automatic logic [DATA_W-1:0] select_opnd(input logic [REG_AW-1:0] r,
                                                      input logic [DATA_W-1:0] rf);
        if (r == '0)
            return '0;
        else if (wb_regwrite && (wb_reg == r))
            return wb_data;
        else
            return rf;
    endfunction

    assign w_opnd1 = select_opnd(w_rs1, read_data1);
    assign w_opnd2 = select_opnd(w_rs2, read_data2);

    assign w_hazard = in_valid && ((w_uses_rs1 && still_busy(w_rs1)) ||
                                   (w_uses_rs2 && still_busy(w_rs2)) ||
                                   (w_regwrite && still_busy(w_rd)));

    assign w_slot_free = !out_valid_q || out_ready;
    assign in_ready    = !reset && (state_q == ST_RUN) && !w_hazard && w_slot_free;
    assign w_issue     = in_valid && in_ready;

    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        out_valid_d    = out_valid_q;
        out_op_d       = out_op_q;
        out_rd_d       = out_rd_q;
        out_a_d        = out_a_q;
        out_b_d        = out_b_q;
        out_regwrite_d = out_regwrite_q;
        illegal_d      = illegal_q;

        if (wb_regwrite)
            busy_d[wb_reg] = 1'b0;

        if (out_ready)
            out_valid_d = 1'b0;

        if (w_issue) begin
            if (w_is_illegal)
                illegal_d = 1'b1;
            if (!w_is_bubble) begin
                out_valid_d    = 1'b1;
                out_op_d       = w_op;
                out_rd_d       = w_rd;
                out_a_d        = w_uses_rs1 ? w_opnd1 : '0;
                out_b_d        = w_uses_rs2 ? w_opnd2 :
                                 ((w_op == c_OP_ADDI) ? w_rs2 : '0);
                out_regwrite_d = w_regwrite;
                if (w_regwrite)
                    busy_d[w_rd] = 1'b1;
                if (w_is_halt)
                    state_d = ST_HALTED;
            end
        end

        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_RUN;
            busy_q         <= '0;
            out_valid_q    <= 1'b0;
            out_op_q       <= '0;
            out_rd_q       <= '0;
            out_a_q        <= '0;
            out_b_q        <= '0;
            out_regwrite_q <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            out_valid_q    <= out_valid_d;
            out_op_q       <= out_op_d;
            out_rd_q       <= out_rd_d;
            out_a_q        <= out_a_d;
            out_b_q        <= out_b_d;
            out_regwrite_q <= out_regwrite_d;
            illegal_q      <= illegal_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_op       = out_op_q;
    assign out_rd       = out_rd_q;
    assign out_a        = out_a_q;
    assign out_b        = out_b_q;
    assign out_regwrite = out_regwrite_q;
    assign illegal      = illegal_q;
    assign halted       = (state_q == ST_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_decode_issue_stage.sv
// ============================================================================
// Module      : tb_decode_issue_stage
// Description : Directed self-checking bench for decode_issue_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_issue_stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic [3:0]  read_reg_num1, read_reg_num2;
    logic [3:0]  read_data1, read_data2;
    logic        wb_regwrite;
    logic [3:0]  wb_reg, wb_data;
    logic        out_valid, out_ready;
    logic [3:0]  out_op, out_rd, out_a, out_b;
    logic        out_regwrite, illegal, halted;

    logic [3:0] rf [16];
    int n_checks = 0;
    int n_errors = 0;

    decode_issue_stage #(.DATA_W(4), .REG_AW(4), .INSTR_W(16)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
        .read_data1(read_data1), .read_data2(read_data2),
        .wb_regwrite(wb_regwrite), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd), .out_a(out_a), .out_b(out_b),
        .out_regwrite(out_regwrite), .illegal(illegal), .halted(halted)
    );

    assign read_data1 = rf[read_reg_num1];
    assign read_data2 = rf[read_reg_num2];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 4'h0;
        rf[1] = 4'h1; rf[2] = 4'h2; rf[5] = 4'h6;
        reset = 1'b1; in_valid = 1'b0; in_instr = 16'h0000;
        wb_regwrite = 1'b0; wb_reg = 4'h0; wb_data = 4'h0; out_ready = 1'b1;

        step(); step();
        in_valid = 1'b1;
        #1 check("rdy_in_reset", in_ready, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_illegal", illegal, 0);
        check("rst_halted", halted, 0);
        check("rst_busy", dut.busy_q, 16'h0000);
        check("rst_in_ready", in_ready, 1);

        // ADD r3,r1,r2
        in_valid = 1'b1; in_instr = 16'h1312;
        #1 check("rnum1", read_reg_num1, 1);
        check("rnum2", read_reg_num2, 2);
        step();
        check("add_valid", out_valid, 1);
        check("add_op", out_op, 1);
        check("add_rd", out_rd, 3);
        check("add_a", out_a, 1);
        check("add_b", out_b, 2);
        check("add_rw", out_regwrite, 1);
        check("add_busy", dut.busy_q, 16'h0008);

        // ADD r4,r3,r3: RAW stall until writeback of r3
        in_instr = 16'h1433;
        #1 check("raw_stall", in_ready, 0);
        step();
        check("raw_drain", out_valid, 0);
        wb_regwrite = 1'b1; wb_reg = 4'h3; wb_data = 4'h5;
        #1 check("raw_release", in_ready, 1);
        step();
        rf[3] = 4'h5;
        wb_regwrite = 1'b0;
        check("fwd_valid", out_valid, 1);
        check("fwd_a", out_a, 5);
        check("fwd_b", out_b, 5);
        check("fwd_rd", out_rd, 4);
        check("fwd_busy", dut.busy_q, 16'h0010);

        // ADDI r0,r5,7: no regwrite, no busy bit
        in_instr = 16'h6057;
        step();
        check("addi0_rw", out_regwrite, 0);
        check("addi0_a", out_a, 6);
        check("addi0_b", out_b, 7);
        check("addi0_busy", dut.busy_q, 16'h0010);

        // ADDI r6,r0,3 with writeback to r0: r0 is never forwarded
        in_instr = 16'h6603;
        wb_regwrite = 1'b1; wb_reg = 4'h0; wb_data = 4'h9;
        step();
        wb_regwrite = 1'b0;
        check("r0_a", out_a, 0);
        check("r0_b", out_b, 3);
        check("r0_busy", dut.busy_q, 16'h0050);

        // Backpressure: AND r7,r1,r2 blocked while slot full
        out_ready = 1'b0; in_instr = 16'h3712;
        #1 check("bp_stall", in_ready, 0);
        step();
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_rd", out_rd, 6);
        check("bp_hold_b", out_b, 3);
        out_ready = 1'b1;
        #1 check("bp_release", in_ready, 1);
        step();
        check("and_op", out_op, 3);
        check("and_rd", out_rd, 7);
        check("and_a", out_a, 1);
        check("and_b", out_b, 2);
        check("and_busy", dut.busy_q, 16'h00D0);

        // Illegal opcode: bubble plus sticky flag
        in_instr = 16'hA000;
        step();
        check("ill_flag", illegal, 1);
        check("ill_valid", out_valid, 0);
        in_instr = 16'h0000;
        repeat (3) step();
        check("ill_sticky", illegal, 1);
        check("nop_valid", out_valid, 0);

        // HALT
        in_instr = 16'hF000;
        step();
        check("halt_flag", halted, 1);
        check("halt_valid", out_valid, 1);
        check("halt_op", out_op, 4'hF);
        check("halt_rw", out_regwrite, 0);
        in_instr = 16'h1112;
        wb_regwrite = 1'b1; wb_reg = 4'h4; wb_data = 4'h1;
        #1 check("halt_rdy", in_ready, 0);
        step();
        wb_regwrite = 1'b0;
        check("halt_busy_clr", dut.busy_q, 16'h00C0);
        check("halt_drain", out_valid, 0);
        repeat (3) step();
        check("halt_rdy_later", in_ready, 0);
        check("halt_stays", halted, 1);

        // Single-cycle reset recovers everything
        reset = 1'b1;
        #1 check("rst2_rdy", in_ready, 0);
        step();
        reset = 1'b0; in_valid = 1'b0;
        #1 check("rst2_halted", halted, 0);
        check("rst2_illegal", illegal, 0);
        check("rst2_rdy", in_ready, 1);
        check("rst2_busy", dut.busy_q, 16'h0000);
        check("rst2_out_op", out_op, 0);

        // WAW: LOAD r9 twice; independent STORE still issues
        in_valid = 1'b1; in_instr = 16'h7910;
        step();
        check("load_a", out_a, 1);
        check("load_rw", out_regwrite, 1);
        check("load_busy", dut.busy_q, 16'h0200);
        in_instr = 16'h7920;
        #1 check("waw_stall", in_ready, 0);
        in_instr = 16'h8012;
        #1 check("store_rdy", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("store_op", out_op, 8);
        check("store_a", out_a, 1);
        check("store_b", out_b, 2);
        check("store_rw", out_regwrite, 0);
        check("store_busy", dut.busy_q, 16'h0200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
